// File: rtl/axi4_lite_master_seq_if.sv
// AXI4-Lite bus bundle between the command sequencer and a slave.
interface axi4_lite_master_seq_if #(
  parameter int addr_width = 3,
  parameter int data_width = 32,
  parameter int strb_width = 4
);
  logic                  awvalid;
  logic                  awready;
  logic [addr_width-1:0] awaddr;
  logic                  awprot;
  logic                  wvalid;
  logic                  wready;
  logic [data_width-1:0] wdata;
  logic [strb_width-1:0] wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [addr_width-1:0] araddr;
  logic                  arprot;
  logic                  rvalid;
  logic                  rready;
  logic [data_width-1:0] rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4_lite_master_seq.sv
// Single-outstanding AXI4-Lite master driven by a one-at-a-time command port.
module axi4_lite_master_seq #(
  parameter int addr_width = 3,
  parameter int data_width = 32,
  parameter int strb_width = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [addr_width-1:0] cmd_addr,
  input  logic [data_width-1:0] cmd_wdata,
  input  logic [strb_width-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  output logic [data_width-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  axi4_lite_master_seq_if.master axi
);

  typedef enum logic [2:0] {IDLE, WR, WRESP, RD_ADDR, RD_DATA, DONE} state_t;

  typedef struct packed {
    logic                  cmd_ready;
    logic                  awvalid;
    logic                  wvalid;
    logic                  bready;
    logic                  arvalid;
    logic                  rready;
    logic                  aw_done;
    logic                  w_done;
    logic [addr_width-1:0] awaddr;
    logic [addr_width-1:0] araddr;
    logic [data_width-1:0] wdata;
    logic [strb_width-1:0] wstrb;
    logic                  rsp_valid;
    logic [data_width-1:0] rsp_rdata;
    logic [1:0]            rsp_resp;
  } regs_t;

  state_t state_q, state_d;
  regs_t  r_q, r_d;

  // Every output is a flop; the next-state process computes their next values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      r_q           <= '0;
      r_q.cmd_ready <= 1'b1;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
    end
  end

  // Next state and next registered outputs; cmd_ready stays low for the
  // rsp_valid cycle so a new command is only taken the cycle after it.
  always_comb begin
    state_d       = state_q;
    r_d           = r_q;
    r_d.rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        r_d.cmd_ready = 1'b1;
        if (r_q.cmd_ready && cmd_valid) begin
          r_d.cmd_ready = 1'b0;
          if (cmd_write) begin
            r_d.awaddr  = cmd_addr;
            r_d.wdata   = cmd_wdata;
            r_d.wstrb   = cmd_wstrb;
            r_d.awvalid = 1'b1;
            r_d.wvalid  = 1'b1;
            r_d.aw_done = 1'b0;
            r_d.w_done  = 1'b0;
            state_d     = WR;
          end else begin
            r_d.araddr  = cmd_addr;
            r_d.arvalid = 1'b1;
            state_d     = RD_ADDR;
          end
        end
      end
      WR: begin
        if (r_q.awvalid && axi.awready) begin
          r_d.awvalid = 1'b0;
          r_d.aw_done = 1'b1;
        end
        if (r_q.wvalid && axi.wready) begin
          r_d.wvalid = 1'b0;
          r_d.w_done = 1'b1;
        end
        if (r_d.aw_done && r_d.w_done) begin
          r_d.bready = 1'b1;
          state_d    = WRESP;
        end
      end
      WRESP: begin
        if (r_q.bready && axi.bvalid) begin
          r_d.rsp_resp = axi.bresp;
          r_d.bready   = 1'b0;
          state_d      = DONE;
        end
      end
      RD_ADDR: begin
        if (r_q.arvalid && axi.arready) begin
          r_d.arvalid = 1'b0;
          r_d.rready  = 1'b1;
          state_d     = RD_DATA;
        end
      end
      RD_DATA: begin
        if (r_q.rready && axi.rvalid) begin
          r_d.rsp_rdata = axi.rdata;
          r_d.rsp_resp  = axi.rresp;
          r_d.rready    = 1'b0;
          state_d       = DONE;
        end
      end
      DONE: begin
        r_d.rsp_valid = 1'b1;
        r_d.cmd_ready = 1'b0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready   = r_q.cmd_ready;
  assign rsp_valid   = r_q.rsp_valid;
  assign rsp_rdata   = r_q.rsp_rdata;
  assign rsp_resp    = r_q.rsp_resp;
  assign axi.awvalid = r_q.awvalid;
  assign axi.awaddr  = r_q.awaddr;
  assign axi.awprot  = 1'b0;
  assign axi.wvalid  = r_q.wvalid;
  assign axi.wdata   = r_q.wdata;
  assign axi.wstrb   = r_q.wstrb;
  assign axi.bready  = r_q.bready;
  assign axi.arvalid = r_q.arvalid;
  assign axi.araddr  = r_q.araddr;
  assign axi.arprot  = 1'b0;
  assign axi.rready  = r_q.rready;

endmodule

// File: tb/tb_axi4_lite_master_seq.sv
// Bench: configurable-latency stub slave, protocol monitor, queue scoreboard.
module tb_axi4_lite_master_seq;
  localparam int AW = 3;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;

  always #5 aclk = ~aclk;

  axi4_lite_master_seq_if #(.addr_width(AW), .data_width(DW), .strb_width(SW)) axi ();

  axi4_lite_master_seq #(.addr_width(AW), .data_width(DW), .strb_width(SW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .axi(axi)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- stub slave ----------------
  int unsigned   aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
  logic          err_en = 1'b0;
  logic [AW-1:0] err_addr = '0;

  logic          aw_got, w_got, ar_got, bvalid_r, rvalid_r;
  int unsigned   aw_wait, w_wait, ar_wait, r_wait;
  logic [AW-1:0] aw_a, ar_a;
  logic [DW-1:0] w_d, rdata_r;
  logic [SW-1:0] w_s;
  logic [1:0]    rresp_r;
  logic [DW-1:0] mem [8];

  assign axi.awready = !aw_got && (aw_wait >= aw_delay);
  assign axi.wready  = !w_got && (w_wait >= w_delay);
  assign axi.arready = !ar_got && !rvalid_r && (ar_wait >= ar_delay);
  assign axi.bvalid  = bvalid_r;
  assign axi.bresp   = 2'b00;
  assign axi.rvalid  = rvalid_r;
  assign axi.rdata   = rdata_r;
  assign axi.rresp   = rresp_r;

  wire           s_aw_hs = axi.awvalid && axi.awready;
  wire           s_w_hs  = axi.wvalid && axi.wready;
  wire           s_ar_hs = axi.arvalid && axi.arready;
  wire [AW-1:0]  s_wa    = s_aw_hs ? axi.awaddr : aw_a;
  wire [DW-1:0]  s_wd    = s_w_hs ? axi.wdata : w_d;
  wire [SW-1:0]  s_ws    = s_w_hs ? axi.wstrb : w_s;
  wire           s_wr_go = (aw_got || s_aw_hs) && (w_got || s_w_hs) && !bvalid_r;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      bvalid_r <= 1'b0; rvalid_r <= 1'b0;
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0; r_wait <= 0;
      aw_a <= '0; ar_a <= '0; w_d <= '0; w_s <= '0; rdata_r <= '0; rresp_r <= '0;
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else begin
      if (s_aw_hs) begin aw_got <= 1'b1; aw_a <= axi.awaddr; aw_wait <= 0; end
      else if (axi.awvalid) aw_wait <= aw_wait + 1;
      if (s_w_hs) begin w_got <= 1'b1; w_d <= axi.wdata; w_s <= axi.wstrb; w_wait <= 0; end
      else if (axi.wvalid) w_wait <= w_wait + 1;
      if (s_wr_go) begin
        for (int b = 0; b < SW; b++) if (s_ws[b]) mem[s_wa][b*8 +: 8] <= s_wd[b*8 +: 8];
        bvalid_r <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (bvalid_r && axi.bready) bvalid_r <= 1'b0;
      if (s_ar_hs) begin
        ar_wait <= 0;
        if (r_delay == 0) begin
          rvalid_r <= 1'b1;
          rdata_r  <= mem[axi.araddr];
          rresp_r  <= (err_en && axi.araddr == err_addr) ? 2'b10 : 2'b00;
        end else begin
          ar_got <= 1'b1; ar_a <= axi.araddr; r_wait <= 1;
        end
      end else begin
        if (axi.arvalid) ar_wait <= ar_wait + 1;
        if (ar_got && !rvalid_r) begin
          if (r_wait >= r_delay) begin
            rvalid_r <= 1'b1;
            rdata_r  <= mem[ar_a];
            rresp_r  <= (err_en && ar_a == err_addr) ? 2'b10 : 2'b00;
            ar_got   <= 1'b0;
          end else r_wait <= r_wait + 1;
        end
      end
      if (rvalid_r && axi.rready) rvalid_r <= 1'b0;
    end
  end

  // ---------------- protocol monitor ----------------
  int   stable_viol = 0, drop_viol = 0, overlap_viol = 0;
  int   b_hs_cnt = 0, aw_hs_cnt = 0, ar_hs_cnt = 0, rsp_cnt = 0;
  logic aw_pend, w_pend, ar_pend, aw_hsp, w_hsp, ar_hsp;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_pend <= 1'b0; w_pend <= 1'b0; ar_pend <= 1'b0;
      aw_hsp <= 1'b0; w_hsp <= 1'b0; ar_hsp <= 1'b0;
    end else begin
      stable_viol <= stable_viol + int'(aw_pend && !axi.awvalid) + int'(w_pend && !axi.wvalid)
                     + int'(ar_pend && !axi.arvalid);
      drop_viol <= drop_viol + int'(aw_hsp && axi.awvalid) + int'(w_hsp && axi.wvalid)
                   + int'(ar_hsp && axi.arvalid);
      overlap_viol <= overlap_viol + int'((axi.awvalid || axi.wvalid || axi.bready)
                                         && (axi.arvalid || axi.rready));
      aw_pend <= axi.awvalid && !axi.awready;
      w_pend  <= axi.wvalid && !axi.wready;
      ar_pend <= axi.arvalid && !axi.arready;
      aw_hsp  <= s_aw_hs;
      w_hsp   <= s_w_hs;
      ar_hsp  <= s_ar_hs;
      b_hs_cnt  <= b_hs_cnt + int'(axi.bvalid && axi.bready);
      aw_hs_cnt <= aw_hs_cnt + int'(s_aw_hs);
      ar_hs_cnt <= ar_hs_cnt + int'(s_ar_hs);
      rsp_cnt   <= rsp_cnt + int'(rsp_valid);
    end
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct packed {
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
  } exp_t;

  exp_t          sb [$];
  logic [DW-1:0] model_mem [8];
  logic [DW-1:0] last_rdata;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model_mem[i] = '0;
    last_rdata = '0;
    sb.delete();
  endtask

  task automatic push_exp(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s);
    exp_t e;
    if (wr) begin
      for (int b = 0; b < SW; b++) if (s[b]) model_mem[a][b*8 +: 8] = d[b*8 +: 8];
      e.rdata = last_rdata;
      e.resp  = 2'b00;
    end else begin
      last_rdata = model_mem[a];
      e.rdata    = model_mem[a];
      e.resp     = (err_en && a == err_addr) ? 2'b10 : 2'b00;
    end
    sb.push_back(e);
  endtask

  // Issues one command, returns what the response port showed and timing facts.
  task automatic do_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, output logic got, output int lat,
                        output logic [DW-1:0] ordata, output logic [1:0] oresp,
                        output logic pulse_ok, output logic busy_bad, output logic ready_after);
    int n;
    n = 0;
    busy_bad = 1'b0;
    @(negedge aclk);
    while (!cmd_ready && n < 100) begin @(negedge aclk); n++; end
    push_exp(wr, a, d, s);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(negedge aclk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      if (cmd_ready) busy_bad = 1'b1;
      @(negedge aclk);
      lat++;
    end
    if (cmd_ready) busy_bad = 1'b1;
    got = rsp_valid; ordata = rsp_rdata; oresp = rsp_resp;
    @(negedge aclk);
    pulse_ok = !rsp_valid;
    ready_after = cmd_ready;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
    checks++; if ({rsp_valid, rsp_resp} !== 3'b0) begin errors++; $display("FAIL rst_rsp: got %b want 000", {rsp_valid, rsp_resp}); end
    checks++; if (rsp_rdata !== '0) begin errors++; $display("FAIL rst_rdata: got %h want 0", rsp_rdata); end
    checks++; if ({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready} !== 5'b0) begin
      errors++; $display("FAIL rst_valids: got %b want 00000", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}); end
    checks++; if ({axi.awaddr, axi.araddr, axi.wstrb} !== '0 || axi.wdata !== '0) begin
      errors++; $display("FAIL rst_bus: awaddr %h araddr %h wdata %h wstrb %h want all 0", axi.awaddr, axi.araddr, axi.wdata, axi.wstrb); end
    checks++; if ({axi.awprot, axi.arprot} !== 2'b00) begin errors++; $display("FAIL rst_prot: got %b want 00", {axi.awprot, axi.arprot}); end
    aresetn = 1'b1;
    model_reset();
    @(negedge aclk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_write_read();
    logic got, pok, bb, ra; int lat; logic [DW-1:0] rd; logic [1:0] rs; exp_t e; int b0;
    aw_delay = 0; w_delay = 0; ar_delay = 0; r_delay = 0; err_en = 1'b0;
    b0 = b_hs_cnt;
    do_cmd(1'b1, 3'd1, 32'd100, 4'hF, got, lat, rd, rs, pok, bb, ra);
    e = sb.pop_front();
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL wr_done: got %b want 1", got); end
    checks++; if (rs !== e.resp) begin errors++; $display("FAIL wr_resp: got %b want %b", rs, e.resp); end
    checks++; if (rd !== e.rdata) begin errors++; $display("FAIL wr_rdata_hold: got %h want %h", rd, e.rdata); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL wr_latency: got %0d want 4", lat); end
    checks++; if (pok !== 1'b1) begin errors++; $display("FAIL wr_pulse_width: rsp_valid still high, want one cycle"); end
    checks++; if (bb !== 1'b0 || ra !== 1'b1) begin errors++; $display("FAIL wr_cmd_ready: busy_high %b after %b want 0 1", bb, ra); end
    checks++; if (b_hs_cnt - b0 !== 1) begin errors++; $display("FAIL wr_b_count: got %0d want 1", b_hs_cnt - b0); end
    do_cmd(1'b0, 3'd1, '0, '0, got, lat, rd, rs, pok, bb, ra);
    e = sb.pop_front();
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL rd_done: got %b want 1", got); end
    checks++; if (rd !== e.rdata) begin errors++; $display("FAIL rd_data: got %h want %h", rd, e.rdata); end
    checks++; if (rs !== e.resp) begin errors++; $display("FAIL rd_resp: got %b want %b", rs, e.resp); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL rd_latency: got %0d want 4", lat); end
    checks++; if (pok !== 1'b1) begin errors++; $display("FAIL rd_pulse_width: rsp_valid still high, want one cycle"); end
  endtask

  task automatic test_strobe();
    logic got, pok, bb, ra; int lat; logic [DW-1:0] rd; logic [1:0] rs; exp_t e;
    do_cmd(1'b1, 3'd3, 32'h1234_5678, 4'b1111, got, lat, rd, rs, pok, bb, ra);
    e = sb.pop_front();
    checks++; if (got !== 1'b1 || rs !== e.resp) begin errors++; $display("FAIL strb_wr1: done %b resp %b want 1 %b", got, rs, e.resp); end
    do_cmd(1'b1, 3'd3, 32'h9999_AAAA, 4'b1010, got, lat, rd, rs, pok, bb, ra);
    e = sb.pop_front();
    checks++; if (got !== 1'b1 || rs !== e.resp) begin errors++; $display("FAIL strb_wr2: done %b resp %b want 1 %b", got, rs, e.resp); end
    do_cmd(1'b0, 3'd3, '0, '0, got, lat, rd, rs, pok, bb, ra);
    e = sb.pop_front();
    checks++; if (rd !== e.rdata) begin errors++; $display("FAIL strb_rd: got %h want %h", rd, e.rdata); end
    checks++; if (rd !== 32'h9934_AA78) begin errors++; $display("FAIL strb_merge: got %h want 9934aa78", rd); end
  endtask

  task automatic test_channel_order();
    logic got, pok, bb, ra; int lat; logic [DW-1:0] rd; logic [1:0] rs; exp_t e;
    int b0, r0, s0, d0;
    for (int k = 0; k < 2; k++) begin
      aw_delay = (k == 0) ? 3 : 0;
      w_delay  = (k == 0) ? 0 : 3;
      b0 = b_hs_cnt; r0 = rsp_cnt; s0 = stable_viol; d0 = drop_viol;
      do_cmd(1'b1, 3'd2, $urandom, 4'hF, got, lat, rd, rs, pok, bb, ra);
      e = sb.pop_front();
      checks++; if (got !== 1'b1 || rs !== e.resp) begin errors++; $display("FAIL order%0d_resp: done %b resp %b want 1 %b", k, got, rs, e.resp); end
      checks++; if (lat !== 7) begin errors++; $display("FAIL order%0d_latency: got %0d want 7", k, lat); end
      checks++; if (b_hs_cnt - b0 !== 1 || rsp_cnt - r0 !== 1) begin
        errors++; $display("FAIL order%0d_counts: b %0d rsp %0d want 1 1", k, b_hs_cnt - b0, rsp_cnt - r0); end
      checks++; if (stable_viol - s0 !== 0) begin errors++; $display("FAIL order%0d_valid_held: withdrawals %0d want 0", k, stable_viol - s0); end
      checks++; if (drop_viol - d0 !== 0) begin errors++; $display("FAIL order%0d_valid_drop: late drops %0d want 0", k, drop_viol - d0); end
    end
    aw_delay = 0; w_delay = 0;
    do_cmd(1'b0, 3'd2, '0, '0, got, lat, rd, rs, pok, bb, ra);
    e = sb.pop_front();
    checks++; if (rd !== e.rdata) begin errors++; $display("FAIL order_readback: got %h want %h", rd, e.rdata); end
  endtask

  task automatic test_read_slverr();
    logic got, pok, bb, ra; int lat; logic [DW-1:0] rd; logic [1:0] rs; exp_t e; int s0;
    err_en = 1'b1; err_addr = 3'd4;
    do_cmd(1'b1, 3'd4, $urandom, 4'hF, got, lat, rd, rs, pok, bb, ra);
    e = sb.pop_front();
    checks++; if (rs !== e.resp) begin errors++; $display("FAIL err_wr_resp: got %b want %b", rs, e.resp); end
    ar_delay = 5; r_delay = 4;
    s0 = stable_viol;
    do_cmd(1'b0, 3'd4, '0, '0, got, lat, rd, rs, pok, bb, ra);
    e = sb.pop_front();
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL err_rd_done: got %b want 1", got); end
    checks++; if (rs !== e.resp) begin errors++; $display("FAIL err_rd_resp: got %b want %b", rs, e.resp); end
    checks++; if (rd !== e.rdata) begin errors++; $display("FAIL err_rd_data: got %h want %h", rd, e.rdata); end
    checks++; if (bb !== 1'b0 || ra !== 1'b1) begin errors++; $display("FAIL err_cmd_ready: busy_high %b after %b want 0 1", bb, ra); end
    checks++; if (stable_viol - s0 !== 0) begin errors++; $display("FAIL err_arvalid_held: withdrawals %0d want 0", stable_viol - s0); end
    checks++; if (lat <= 4) begin errors++; $display("FAIL err_latency: got %0d want more than 4", lat); end
    ar_delay = 0; r_delay = 0; err_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic          wr [6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [AW-1:0] ad [6]  = '{3'd5, 3'd5, 3'd6, 3'd6, 3'd5, 3'd5};
    logic [SW-1:0] st [6]  = '{4'hF, 4'h0, 4'h3, 4'h0, 4'hC, 4'h0};
    logic [DW-1:0] dt [6];
    int issued, done, n, r0, aw0, ar0, ov0;
    logic pending;
    exp_t e;
    for (int i = 0; i < 6; i++) dt[i] = $urandom;
    issued = 0; done = 0; n = 0; pending = 1'b1;
    r0 = rsp_cnt; aw0 = aw_hs_cnt; ar0 = ar_hs_cnt; ov0 = overlap_viol;
    while (done < 6 && n < 300) begin
      @(negedge aclk);
      n++;
      if (pending) begin
        pending = 1'b0;
        if (issued < 6) begin
          cmd_valid = 1'b1; cmd_write = wr[issued]; cmd_addr = ad[issued];
          cmd_wdata = dt[issued]; cmd_wstrb = st[issued];
        end else cmd_valid = 1'b0;
      end
      if (rsp_valid) begin
        done++;
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL b2b_extra_rsp: response %0d with nothing expected", done); end
        else begin
          e = sb.pop_front();
          if (rsp_rdata !== e.rdata || rsp_resp !== e.resp) begin
            errors++; $display("FAIL b2b_rsp%0d: got %h/%b want %h/%b", done, rsp_rdata, rsp_resp, e.rdata, e.resp); end
        end
      end
      if (cmd_valid && cmd_ready) begin
        push_exp(cmd_write, cmd_addr, cmd_wdata, cmd_wstrb);
        issued++;
        pending = 1'b1;
      end
    end
    cmd_valid = 1'b0;
    repeat (8) @(negedge aclk);
    checks++; if (done !== 6) begin errors++; $display("FAIL b2b_done: got %0d want 6", done); end
    checks++; if (rsp_cnt - r0 !== 6) begin errors++; $display("FAIL b2b_rsp_count: got %0d want 6", rsp_cnt - r0); end
    checks++; if (aw_hs_cnt - aw0 !== 3 || ar_hs_cnt - ar0 !== 3) begin
      errors++; $display("FAIL b2b_txn_count: aw %0d ar %0d want 3 3", aw_hs_cnt - aw0, ar_hs_cnt - ar0); end
    checks++; if (overlap_viol - ov0 !== 0) begin errors++; $display("FAIL b2b_overlap: got %0d want 0", overlap_viol - ov0); end
  endtask

  task automatic test_reset_mid();
    logic got, pok, bb, ra; int lat; logic [DW-1:0] rd; logic [1:0] rs; exp_t e; int r0, n;
    aw_delay = 10; w_delay = 10;
    @(negedge aclk);
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge aclk); n++; end
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd7; cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF;
    @(negedge aclk);
    cmd_valid = 1'b0;
    @(negedge aclk);
    checks++; if (axi.awvalid !== 1'b1 || axi.wvalid !== 1'b1) begin
      errors++; $display("FAIL mid_pre_valid: aw %b w %b want 1 1", axi.awvalid, axi.wvalid); end
    r0 = rsp_cnt;
    #2 aresetn = 1'b0;
    #1;
    checks++; if (axi.awvalid !== 1'b0 || axi.wvalid !== 1'b0) begin
      errors++; $display("FAIL mid_async_drop: aw %b w %b want 0 0", axi.awvalid, axi.wvalid); end
    checks++; if (cmd_ready !== 1'b1 || axi.awaddr !== '0 || axi.wdata !== '0) begin
      errors++; $display("FAIL mid_async_regs: ready %b awaddr %h wdata %h want 1 0 0", cmd_ready, axi.awaddr, axi.wdata); end
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    model_reset();
    aw_delay = 0; w_delay = 0;
    repeat (12) @(negedge aclk);
    checks++; if (rsp_cnt - r0 !== 0) begin errors++; $display("FAIL mid_no_rsp: got %0d want 0", rsp_cnt - r0); end
    do_cmd(1'b1, 3'd7, 32'h0BAD_F00D, 4'hF, got, lat, rd, rs, pok, bb, ra);
    e = sb.pop_front();
    checks++; if (got !== 1'b1 || rs !== e.resp || rd !== e.rdata) begin
      errors++; $display("FAIL mid_after_wr: done %b resp %b rdata %h want 1 %b %h", got, rs, rd, e.resp, e.rdata); end
    do_cmd(1'b0, 3'd7, '0, '0, got, lat, rd, rs, pok, bb, ra);
    e = sb.pop_front();
    checks++; if (got !== 1'b1 || rd !== e.rdata || lat !== 4) begin
      errors++; $display("FAIL mid_after_rd: done %b rdata %h lat %0d want 1 %h 4", got, rd, lat, e.rdata); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_read();
    test_strobe();
    test_channel_order();
    test_read_slverr();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
